ysyx_25040109_mdu: RTL

Multi-cycle, parametrised RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the NPC execute stage. It replaces single-cycle combinational `*`, `/` and `%` with an iterative shift-add multiplier and a restoring divider. Operands enter and results leave through valid/ready handshakes, so EXU stalls while the unit is busy. A destination tag travels with each operation for writeback.

---
 rtl/ysyx_25040109_mdu_if.sv | 27 ++
 rtl/ysyx_25040109_mdu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040109_mdu_if.sv
// Request/response handshake bundle for the ysyx_25040109_mdu multiply/divide unit.
// The master modport drives requests and consumes results; the slave modport is the unit side.
interface ysyx_25040109_mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/ysyx_25040109_mdu.sv
// Iterative RV M-extension unit: radix-2 shift-add multiplier and restoring divider on magnitudes.
// Optional macro YSYX_25040109_MDU_FASTZERO_EN short-circuits zero operands to a 1-cycle result.
module ysyx_25040109_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_25040109_mdu_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_MAX = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Request decode: funct3 bit 2 selects divide, bit 1 selects remainder within divide.
  logic            is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic            b_zero, ovf, fast_zero, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_div   = bus.in_op[2];
    is_rem   = bus.in_op[1];
    a_signed = (bus.in_op == 3'd1) || (bus.in_op == 3'd2) ||
               (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    b_signed = (bus.in_op == 3'd1) || (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    a_neg    = a_signed & bus.in_a[XLEN-1];
    b_neg    = b_signed & bus.in_b[XLEN-1];
    a_mag    = a_neg ? -bus.in_a : bus.in_a;
    b_mag    = b_neg ? -bus.in_b : bus.in_b;
    b_zero   = (bus.in_b == '0);
    ovf      = is_div & ~bus.in_op[0] & (bus.in_a == MIN_INT) & (bus.in_b == '1);
`ifdef YSYX_25040109_MDU_FASTZERO_EN
    fast_zero = is_div ? ((bus.in_a == '0) & ~b_zero)
                       : ((bus.in_a == '0) | b_zero);
`else
    fast_zero = 1'b0;
`endif
    special     = (is_div & (b_zero | ovf)) | fast_zero;
    special_res = '0;
    if (is_div && b_zero) begin
      special_res = is_rem ? bus.in_a : '1;
    end else if (ovf) begin
      special_res = is_rem ? '0 : bus.in_a;
    end
  end

  // One multiply step: conditionally add multiplicand to the high half, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n, mul_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  // One divide step: shift in the next dividend bit and subtract if the divisor fits.
  logic [XLEN:0]   div_shift;
  logic            div_ok;
  logic [XLEN-1:0] div_diff, div_rem_n, div_quo_n, div_raw, div_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    prod     = {mul_hi_n, mul_lo_n};
    prod_fix = neg_q ? -prod : prod;
    mul_res  = (op_q == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_rem_n = div_ok ? div_diff : div_shift[XLEN-1:0];
    div_quo_n = {lo_q[XLEN-2:0], div_ok};
    div_raw   = op_q[1] ? div_rem_n : div_quo_n;
    div_res   = neg_q ? -div_raw : div_raw;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    tag_d       = tag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d       = bus.in_op[1:0];
          tag_d      = bus.in_tag;
          in_ready_d = 1'b0;
          cnt_d      = CNT_MAX;
          hi_d       = '0;
          if (special) begin
            result_d    = special_res;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (is_div) begin
            neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
            lo_d    = a_mag;
            opnd_d  = b_mag;
            state_d = S_DIV;
          end else begin
            neg_d   = a_neg ^ b_neg;
            lo_d    = b_mag;
            opnd_d  = a_mag;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_hi_n;
        lo_d  = mul_lo_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d    = mul_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DIV: begin
        hi_d  = div_rem_n;
        lo_d  = div_quo_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d    = div_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
endmodule
